// File: rtl/snake_pkg.sv
// Shared codes for the snake movement scheduler: directions, master-state code,
// default grid size and the step-sequencer state encoding.
package snake_pkg;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;
    localparam logic [1:0] MSM_PLAY  = 2'b01;

    localparam int GRID_X_DEF = 160;
    localparam int GRID_Y_DEF = 120;

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_HEAD_RD, ST_HEAD_CALC,
        ST_SH_RD, ST_SH_WR, ST_HEAD_WR, ST_CHECK
    } state_t;
endpackage

// File: rtl/snake_tick_gen.sv
// Speed-scaled game tick: period shrinks with score down to a floor, and the
// counter only advances while enabled so a pause resumes from the held count.
module snake_tick_gen #(
    parameter int unsigned BASE_TICK  = 10_000_000,
    parameter int unsigned SPEED_STEP = 500_000,
    parameter int unsigned MIN_TICK   = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] score,
    output logic       tick
);
    logic [31:0] count;
    logic [31:0] dec;
    logic [31:0] period;

    // Saturate instead of letting the subtraction wrap for large scores.
    always_comb begin
        dec = 32'(score) * SPEED_STEP;
        if (BASE_TICK > dec && (BASE_TICK - dec) > MIN_TICK)
            period = BASE_TICK - dec;
        else
            period = MIN_TICK;
    end

    // >= keeps the counter sane if the period shrinks below the current count.
    assign tick = en && (count >= period - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= tick ? '0 : count + 32'd1;
    end
endmodule

// File: rtl/snake_move_sched.sv
// Snake step sequencer over the single-port body RAM: init, head calc, body shift,
// head write, collision/capture check. Define WRAP_WALLS_EN for wrap-around edges.
module snake_move_sched
    import snake_pkg::*;
#(
    parameter int unsigned BASE_TICK  = 10_000_000,
    parameter int unsigned SPEED_STEP = 500_000,
    parameter int unsigned MIN_TICK   = 2_000_000,
    parameter int          MAX_LEN    = 16,
    parameter int          INIT_LEN   = 4,
    parameter int          GRID_X     = GRID_X_DEF,
    parameter int          GRID_Y     = GRID_Y_DEF,
    localparam int         IW         = $clog2(MAX_LEN)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          PAUSE,
    input  logic [1:0]    MSM_STATE,
    input  logic [1:0]    NAV_STATE,
    input  logic [3:0]    SCORE_COUNT,
    input  logic [7:0]    TARGET_ADDR_X,
    input  logic [6:0]    TARGET_ADDR_Y,
    output logic [IW-1:0] SEG_IDX,
    input  logic [7:0]    SEG_RD_X,
    input  logic [6:0]    SEG_RD_Y,
    output logic          SEG_WE,
    output logic [7:0]    SEG_WR_X,
    output logic [6:0]    SEG_WR_Y,
    output logic [IW:0]   LENGTH,
    output logic          TARGET_REACHED,
    output logic          DEATH,
    output logic          BUSY
);
`ifdef WRAP_WALLS_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [IW:0] LEN_MAX  = (IW+1)'(MAX_LEN);
    localparam logic [IW:0] LEN_INIT = (IW+1)'(INIT_LEN);

    state_t      state;
    logic [1:0]  cur_dir;
    logic [IW:0] cnt;
    logic [7:0]  head_x, wr_x, calc_x;
    logic [6:0]  head_y, wr_y, calc_y;
    logic        wall_hit, self_hit, grow_step, grow_pending;
    logic        calc_edge, tick, tick_en, grow;
    logic [IW:0] start;

    assign tick_en = (MSM_STATE == MSM_PLAY) && !PAUSE && !DEATH && (state == ST_IDLE);

    snake_tick_gen #(
        .BASE_TICK (BASE_TICK),
        .SPEED_STEP(SPEED_STEP),
        .MIN_TICK  (MIN_TICK)
    ) u_tick (
        .clk  (CLK),
        .rst  (RESET),
        .en   (tick_en),
        .score(SCORE_COUNT),
        .tick (tick)
    );

    assign grow  = grow_pending && (LENGTH < LEN_MAX);
    assign start = grow ? LENGTH : LENGTH - 1'b1;

    // Shift-loop data goes straight from the RAM read port back to its write port.
    assign SEG_WR_X = (state == ST_SH_WR) ? SEG_RD_X : wr_x;
    assign SEG_WR_Y = (state == ST_SH_WR) ? SEG_RD_Y : wr_y;

    // Always compute the wrapped coordinate; the edge flag only kills the step without wrap.
    always_comb begin
        calc_x    = SEG_RD_X;
        calc_y    = SEG_RD_Y;
        calc_edge = 1'b0;
        case (cur_dir)
            DIR_UP: begin
                calc_edge = (SEG_RD_Y == 7'd0);
                calc_y    = calc_edge ? 7'(GRID_Y - 1) : SEG_RD_Y - 7'd1;
            end
            DIR_DOWN: begin
                calc_edge = (SEG_RD_Y == 7'(GRID_Y - 1));
                calc_y    = calc_edge ? 7'd0 : SEG_RD_Y + 7'd1;
            end
            DIR_LEFT: begin
                calc_edge = (SEG_RD_X == 8'd0);
                calc_x    = calc_edge ? 8'(GRID_X - 1) : SEG_RD_X - 8'd1;
            end
            default: begin
                calc_edge = (SEG_RD_X == 8'(GRID_X - 1));
                calc_x    = calc_edge ? 8'd0 : SEG_RD_X + 8'd1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_INIT;
            cur_dir        <= DIR_RIGHT;
            cnt            <= '0;
            head_x         <= '0;
            head_y         <= '0;
            wr_x           <= '0;
            wr_y           <= '0;
            wall_hit       <= 1'b0;
            self_hit       <= 1'b0;
            grow_step      <= 1'b0;
            grow_pending   <= 1'b0;
            SEG_IDX        <= '0;
            SEG_WE         <= 1'b0;
            LENGTH         <= '0;
            TARGET_REACHED <= 1'b0;
            DEATH          <= 1'b0;
            BUSY           <= 1'b1;
        end else begin
            SEG_WE         <= 1'b0;
            TARGET_REACHED <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (cnt == LEN_INIT) begin
                        LENGTH <= LEN_INIT;
                        BUSY   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        SEG_WE  <= 1'b1;
                        SEG_IDX <= cnt[IW-1:0];
                        wr_x    <= 8'(GRID_X / 2) - 8'(cnt);
                        wr_y    <= 7'(GRID_Y / 2);
                        cnt     <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (tick) begin
                        if (NAV_STATE != (cur_dir ^ 2'b10))
                            cur_dir <= NAV_STATE;
                        grow_step <= grow;
                        cnt       <= start;
                        SEG_IDX   <= '0;
                        wall_hit  <= 1'b0;
                        self_hit  <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= ST_HEAD_RD;
                    end
                end
                ST_HEAD_RD: state <= ST_HEAD_CALC;
                ST_HEAD_CALC: begin
                    head_x   <= calc_x;
                    head_y   <= calc_y;
                    wall_hit <= calc_edge && !WRAP;
                    if (cnt == '0) begin
                        SEG_IDX <= '0;
                        SEG_WE  <= !(calc_edge && !WRAP);
                        wr_x    <= calc_x;
                        wr_y    <= calc_y;
                        state   <= ST_HEAD_WR;
                    end else begin
                        SEG_IDX <= IW'(cnt - 1'b1);
                        state   <= ST_SH_RD;
                    end
                end
                ST_SH_RD: begin
                    SEG_IDX <= cnt[IW-1:0];
                    SEG_WE  <= !wall_hit;
                    state   <= ST_SH_WR;
                end
                ST_SH_WR: begin
                    if (SEG_RD_X == head_x && SEG_RD_Y == head_y)
                        self_hit <= 1'b1;
                    cnt <= cnt - 1'b1;
                    if (cnt == (IW+1)'(1)) begin
                        SEG_IDX <= '0;
                        SEG_WE  <= !wall_hit;
                        wr_x    <= head_x;
                        wr_y    <= head_y;
                        state   <= ST_HEAD_WR;
                    end else begin
                        SEG_IDX <= IW'(cnt - 2'd2);
                        state   <= ST_SH_RD;
                    end
                end
                ST_HEAD_WR: begin
                    if (grow_step) begin
                        LENGTH       <= LENGTH + 1'b1;
                        grow_pending <= 1'b0;
                    end
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (wall_hit || self_hit)
                        DEATH <= 1'b1;
                    else if (head_x == TARGET_ADDR_X && head_y == TARGET_ADDR_Y) begin
                        TARGET_REACHED <= 1'b1;
                        grow_pending   <= (LENGTH < LEN_MAX);
                    end
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_move_sched.sv
// Scoreboard bench: stimulus queues expected RAM writes and per-step results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_snake_move_sched;
    import snake_pkg::*;

    logic       CLK = 1'b0, RESET = 1'b1, PAUSE = 1'b0;
    logic [1:0] MSM_STATE = 2'b00, NAV_STATE = DIR_RIGHT;
    logic [3:0] SCORE_COUNT = 4'd0;
    logic [7:0] TARGET_ADDR_X = 8'd0;
    logic [6:0] TARGET_ADDR_Y = 7'd0;
    logic [3:0] SEG_IDX;
    logic [7:0] SEG_RD_X, SEG_WR_X;
    logic [6:0] SEG_RD_Y, SEG_WR_Y;
    logic       SEG_WE, TARGET_REACHED, DEATH, BUSY;
    logic [4:0] LENGTH;

    always #5 CLK = ~CLK;

    snake_move_sched #(
        .BASE_TICK(100), .SPEED_STEP(5), .MIN_TICK(40), .MAX_LEN(16), .INIT_LEN(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PAUSE(PAUSE), .MSM_STATE(MSM_STATE),
        .NAV_STATE(NAV_STATE), .SCORE_COUNT(SCORE_COUNT),
        .TARGET_ADDR_X(TARGET_ADDR_X), .TARGET_ADDR_Y(TARGET_ADDR_Y),
        .SEG_IDX(SEG_IDX), .SEG_RD_X(SEG_RD_X), .SEG_RD_Y(SEG_RD_Y),
        .SEG_WE(SEG_WE), .SEG_WR_X(SEG_WR_X), .SEG_WR_Y(SEG_WR_Y),
        .LENGTH(LENGTH), .TARGET_REACHED(TARGET_REACHED), .DEATH(DEATH), .BUSY(BUSY)
    );

    // Body RAM model with one-cycle read latency and a bench-side preload port.
    logic [7:0] mem_x [16];
    logic [6:0] mem_y [16];
    logic       pre_we = 1'b0;
    logic [3:0] pre_idx = 4'd0;
    logic [7:0] pre_x = 8'd0;
    logic [6:0] pre_y = 7'd0;

    always @(posedge CLK) begin
        if (pre_we) begin
            mem_x[pre_idx] <= pre_x;
            mem_y[pre_idx] <= pre_y;
        end else if (SEG_WE) begin
            mem_x[SEG_IDX] <= SEG_WR_X;
            mem_y[SEG_IDX] <= SEG_WR_Y;
        end
        SEG_RD_X <= mem_x[SEG_IDX];
        SEG_RD_Y <= mem_y[SEG_IDX];
    end

    typedef struct {int idx; int x; int y;} wr_t;
    typedef struct {int len; int tr; int death; int dur; int gap;} step_t;
    wr_t   wq[$];
    step_t sq[$];
    int    total = 0, passed = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    task automatic push_wr(int idx, int x, int y);
        wr_t w;
        w.idx = idx; w.x = x; w.y = y;
        wq.push_back(w);
    endtask

    task automatic push_step(int len, int tr, int death, int dur, int gap);
        step_t s;
        s.len = len; s.tr = tr; s.death = death; s.dur = dur; s.gap = gap;
        sq.push_back(s);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((sq.size() != 0 || wq.size() != 0) && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        chk("drain_pending", sq.size() + wq.size(), 0);
    endtask

    // dur = BUSY-high cycles (4 + 2*start), gap = idle cycles before the tick; 0 skips.
    logic  busy_q = 1'b1;
    int    hi_cnt = 0, lo_cnt = 0, last_gap = 0;
    wr_t   mw;
    step_t ms;
    always @(negedge CLK) begin
        if (RESET) begin
            busy_q = 1'b1; hi_cnt = 0; lo_cnt = 0;
        end else begin
            if (SEG_WE) begin
                if (wq.size() == 0) chk("unexpected_write_idx", int'(SEG_IDX), -1);
                else begin
                    mw = wq.pop_front();
                    chk("wr_idx", int'(SEG_IDX), mw.idx);
                    chk("wr_x", int'(SEG_WR_X), mw.x);
                    chk("wr_y", int'(SEG_WR_Y), mw.y);
                end
            end
            if (!busy_q && BUSY) begin
                last_gap = lo_cnt; lo_cnt = 0; hi_cnt = 0;
            end
            if (busy_q && !BUSY) begin
                if (sq.size() == 0) chk("unexpected_step_len", int'(LENGTH), -1);
                else begin
                    ms = sq.pop_front();
                    chk("step_length", int'(LENGTH), ms.len);
                    chk("step_target_reached", int'(TARGET_REACHED), ms.tr);
                    chk("step_death", int'(DEATH), ms.death);
                    if (ms.dur != 0) chk("step_busy_cycles", hi_cnt, ms.dur);
                    if (ms.gap != 0) chk("tick_period", last_gap, ms.gap);
                end
                hi_cnt = 0; lo_cnt = 0;
            end
            if (BUSY) hi_cnt++; else lo_cnt++;
            busy_q = BUSY;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        // Init: snake laid out leftwards from grid centre.
        for (int i = 0; i < 4; i++) push_wr(i, 80 - i, 60);
        push_step(4, 0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        chk("rst_seg_idx", int'(SEG_IDX), 0);
        chk("rst_seg_we", int'(SEG_WE), 0);
        chk("rst_wr_x", int'(SEG_WR_X), 0);
        chk("rst_wr_y", int'(SEG_WR_Y), 0);
        chk("rst_length", int'(LENGTH), 0);
        chk("rst_target_reached", int'(TARGET_REACHED), 0);
        chk("rst_death", int'(DEATH), 0);
        chk("rst_busy", int'(BUSY), 1);
        RESET = 1'b0;
        drain(50);

        // Step A: one move right, no capture.
        MSM_STATE = MSM_PLAY;
        push_wr(3, 78, 60); push_wr(2, 79, 60); push_wr(1, 80, 60); push_wr(0, 81, 60);
        push_step(4, 0, 0, 10, 100);
        drain(300);
        chk("ramA_head_x", int'(mem_x[0]), 81);
        chk("ramA_tail_x", int'(mem_x[3]), 78);

        // Step B: capture at (82,60).
        TARGET_ADDR_X = 8'd82; TARGET_ADDR_Y = 7'd60;
        push_wr(3, 79, 60); push_wr(2, 80, 60); push_wr(1, 81, 60); push_wr(0, 82, 60);
        push_step(4, 1, 0, 10, 100);
        drain(300);

        // Step C: grows, tail kept; LEFT request is a reversal and is ignored.
        TARGET_ADDR_X = 8'd0; TARGET_ADDR_Y = 7'd0; NAV_STATE = DIR_LEFT;
        push_wr(4, 79, 60); push_wr(3, 80, 60); push_wr(2, 81, 60); push_wr(1, 82, 60);
        push_wr(0, 83, 60);
        push_step(5, 0, 0, 12, 100);
        drain(300);
        chk("ramC_tail_x", int'(mem_x[4]), 79);

        // Step D: turn up, max score -> floored period.
        NAV_STATE = DIR_UP; SCORE_COUNT = 4'd15;
        push_wr(4, 80, 60); push_wr(3, 81, 60); push_wr(2, 82, 60); push_wr(1, 83, 60);
        push_wr(0, 83, 59);
        push_step(5, 0, 0, 12, 40);
        drain(300);

        // Step E: turn right; 25-cycle pause mid-count extends the gap to 65.
        NAV_STATE = DIR_RIGHT;
        push_wr(4, 81, 60); push_wr(3, 82, 60); push_wr(2, 83, 60); push_wr(1, 83, 59);
        push_wr(0, 84, 59);
        push_step(5, 0, 0, 12, 65);
        repeat (10) @(negedge CLK);
        PAUSE = 1'b1;
        repeat (25) @(negedge CLK);
        PAUSE = 1'b0;
        drain(300);

        // Step F: head placed at the right edge.
        for (int i = 0; i < 5; i++) begin
            pre_we = 1'b1; pre_idx = 4'(i); pre_x = 8'(159 - i); pre_y = 7'd60;
            @(negedge CLK);
        end
        pre_we = 1'b0;
`ifdef WRAP_WALLS_EN
        push_wr(4, 156, 60); push_wr(3, 157, 60); push_wr(2, 158, 60); push_wr(1, 159, 60);
        push_wr(0, 0, 60);
        push_step(5, 0, 0, 12, 40);
        drain(300);
        chk("wrap_head_x", int'(mem_x[0]), 0);
        chk("wrap_tail_x", int'(mem_x[4]), 156);
        MSM_STATE = 2'b00;
        repeat (150) @(negedge CLK);
        chk("wrap_alive", int'(DEATH), 0);
`else
        push_step(5, 0, 1, 12, 40);
        drain(300);
        chk("wall_ram_head_x", int'(mem_x[0]), 159);
        chk("wall_ram_tail_x", int'(mem_x[4]), 155);
        repeat (150) @(negedge CLK);
        chk("death_sticky", int'(DEATH), 1);
        chk("no_step_after_death", int'(BUSY), 0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
